mult_seq_ctrl: RTL and testbench



---
 rtl/mult_seq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mult_seq_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: unsigned WIDTH x WIDTH multiplier that reuses a single 2x2
// array multiplier over every 2-bit digit pair of the operands. It accumulates
// the shifted partial products internally. Operands and the product move over
// valid/ready handshakes.
// Optional build macro MULT_SEQ_EARLY_EXIT_EN: a zero operand skips RUN and
// the controller goes straight to DONE with a zero product.
module mult_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int D  = WIDTH / 2;
  localparam int IW = (D > 1) ? $clog2(D) : 1;
  localparam int PW = 2 * WIDTH;
  localparam int SW = $clog2(PW) + 1;
  localparam logic [IW-1:0] D_LAST = IW'(D - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Gate-level 2x2 array multiplier: four AND partial products and two half adders.
  function automatic logic [3:0] mult2by2(input logic [1:0] x, input logic [1:0] y);
    logic pp00, pp01, pp10, pp11, c1;
    pp00 = x[0] & y[0];
    pp10 = x[1] & y[0];
    pp01 = x[0] & y[1];
    pp11 = x[1] & y[1];
    c1   = pp10 & pp01;
    return {pp11 & c1, pp11 ^ c1, pp10 ^ pp01, pp00};
  endfunction

  state_t          state_r;
  state_t          state_next_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [IW-1:0]   i_r;
  logic [IW-1:0]   j_r;
  logic [PW-1:0]   acc_r;
  logic [PW-1:0]   acc_next_s;
  logic [PW-1:0]   acc_sum_s;
  logic [PW-1:0]   term_s;
  logic [1:0]      x_s;
  logic [1:0]      y_s;
  logic [3:0]      p_s;
  logic [SW-1:0]   digit_sum_s;
  logic [SW-1:0]   shift_s;
  logic            last_s;
  logic            accept_s;

  // Current digit pair, its weighted partial product and the running sum.
  always_comb begin
    x_s         = a_r[{i_r, 1'b0} +: 2];
    y_s         = b_r[{j_r, 1'b0} +: 2];
    p_s         = mult2by2(x_s, y_s);
    digit_sum_s = SW'(i_r) + SW'(j_r);
    shift_s     = digit_sum_s << 1;
    term_s      = PW'(p_s) << shift_s;
    acc_sum_s   = acc_r + term_s;
    last_s      = (i_r == D_LAST) && (j_r == D_LAST);
    accept_s    = (state_r == ST_IDLE) && in_valid;
  end

  // Next-state and next-accumulator decode.
  always_comb begin
    state_next_s = state_r;
    acc_next_s   = acc_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          acc_next_s = {PW{1'b0}};
`ifdef MULT_SEQ_EARLY_EXIT_EN
          if ((a == {WIDTH{1'b0}}) || (b == {WIDTH{1'b0}})) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_RUN;
          end
`else
          state_next_s = ST_RUN;
`endif
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_next_s = acc_sum_s;
        if (last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        acc_next_s   = {PW{1'b0}};
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand latch, digit counters and accumulator; counters hold after the last pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r   <= {WIDTH{1'b0}};
      b_r   <= {WIDTH{1'b0}};
      i_r   <= {IW{1'b0}};
      j_r   <= {IW{1'b0}};
      acc_r <= {PW{1'b0}};
    end else begin
      acc_r <= acc_next_s;
      if (accept_s) begin
        a_r <= a;
        b_r <= b;
        i_r <= {IW{1'b0}};
        j_r <= {IW{1'b0}};
      end else if ((state_r == ST_RUN) && !last_s) begin
        if (i_r == D_LAST) begin
          i_r <= {IW{1'b0}};
          j_r <= j_r + IW'(1);
        end else begin
          i_r <= i_r + IW'(1);
        end
      end
    end
  end

  // Registered handshake/status outputs derived from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      product   <= {PW{1'b0}};
    end else begin
      in_ready  <= (state_next_s == ST_IDLE);
      busy      <= (state_next_s != ST_IDLE);
      out_valid <= (state_next_s == ST_DONE);
      product   <= (state_next_s == ST_DONE) ? acc_next_s : {PW{1'b0}};
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed vector table, reset and
// backpressure sequences, random sweep at WIDTH=8 and exhaustive WIDTH=4.
module tb_mult_seq_ctrl;

  localparam int W  = 8;
  localparam int D  = W / 2;
  localparam int W4 = 4;
  localparam int D4 = W4 / 2;
  localparam int BUDGET = 40;

  logic           clk;
  logic           reset;
  logic           in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0]   a, b;
  logic [2*W-1:0] product;
  logic            in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [W4-1:0]   a4, b4;
  logic [2*W4-1:0] product4;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    int             hold;
    bit             poke;
    logic [2*W-1:0] prod;
  } vec_t;

  vec_t vecs [10];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mult_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy)
  );

  mult_seq_ctrl #(.WIDTH(W4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
    .product(product4), .busy(busy4)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference latency: cycles from the accepting edge to the first cycle out_valid is seen.
  function automatic int ref_lat(input int dd, input longint x, input longint y);
`ifdef MULT_SEQ_EARLY_EXIT_EN
    if ((x == 0) || (y == 0)) return 0;
`endif
    return dd * dd;
  endfunction

  // One full transaction on the WIDTH=8 instance; called at a negedge with the DUT idle.
  task automatic do_op8(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int hold, input bit poke, input logic [2*W-1:0] exp_prod);
    int cyc;
    int busy_cnt;
    int exp_lat;
    bit run_ok;
    bit stable_ok;
    logic [2*W-1:0] held;
    exp_lat = ref_lat(D, longint'(x), longint'(y));
    chk({nm, " in_ready_idle"}, 64'(in_ready), 64'd1);
    out_ready = (hold == 0);
    a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; a = ~x; b = ~y;
    cyc = 0; busy_cnt = 0; run_ok = 1'b1;
    while (!out_valid && cyc < BUDGET) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) run_ok = 1'b0;
      busy_cnt++;
      if (poke && cyc == 3) begin in_valid = 1'b1; a = 8'h01; b = 8'h01; end
      if (poke && cyc == 8) in_valid = 1'b0;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk({nm, " latency"}, 64'(cyc), 64'(exp_lat));
    chk({nm, " product"}, 64'(product), 64'(exp_prod));
    chk({nm, " run_handshake"}, 64'(run_ok), 64'd1);
    held = product; stable_ok = 1'b1;
    for (int h = 0; h < hold; h++) begin
      if (out_valid !== 1'b1 || product !== held || in_ready !== 1'b0 || busy !== 1'b1) stable_ok = 1'b0;
      busy_cnt++;
      if (h == 2) begin in_valid = 1'b1; a = 8'h01; b = 8'h01; end else in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (hold > 0) chk({nm, " backpressure_stable"}, 64'(stable_ok), 64'd1);
    if (busy === 1'b1) busy_cnt++;
    out_ready = 1'b1;
    @(negedge clk);
    chk({nm, " back_to_idle"}, 64'({out_valid, in_ready, busy}), 64'b010);
    chk({nm, " busy_cycles"}, 64'(busy_cnt), 64'(exp_lat + 1 + hold));
  endtask

  // One transaction on the WIDTH=4 instance with out_ready held high.
  task automatic do_op4(input logic [W4-1:0] x, input logic [W4-1:0] y);
    int cyc;
    out_ready4 = 1'b1;
    a4 = x; b4 = y; in_valid4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
    cyc = 0;
    while (!out_valid4 && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    chk("w4 latency", 64'(cyc), 64'(ref_lat(D4, longint'(x), longint'(y))));
    chk("w4 product", 64'(product4), 64'(int'(x) * int'(y)));
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{8'hFF, 8'hFF, 0, 1'b0, 16'hFE01};
    vecs[1] = '{8'hA5, 8'h3C, 0, 1'b1, 16'h26AC};
    vecs[2] = '{8'h02, 8'h03, 0, 1'b0, 16'h0006};
    vecs[3] = '{8'h12, 8'h34, 5, 1'b0, 16'h03A8};
    vecs[4] = '{8'h00, 8'hC8, 0, 1'b0, 16'h0000};
    vecs[5] = '{8'hC8, 8'h00, 2, 1'b0, 16'h0000};
    vecs[6] = '{8'h80, 8'h80, 0, 1'b0, 16'h4000};
    vecs[7] = '{8'hFF, 8'h01, 1, 1'b0, 16'h00FF};
    vecs[8] = '{8'h01, 8'hFF, 0, 1'b0, 16'h00FF};
    vecs[9] = '{8'h0F, 8'hF0, 0, 1'b0, 16'h0E10};

    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    in_valid4 = 1'b0; out_ready4 = 1'b1; a4 = '0; b4 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset state", 64'({in_ready, out_valid, busy}), 64'b100);
    chk("reset product", 64'(product), 64'd0);
    @(negedge clk);

    // Directed table, applied back to back.
    for (int n = 0; n < 10; n++) begin
      do_op8($sformatf("vec%0d", n), vecs[n].a, vecs[n].b, vecs[n].hold, vecs[n].poke, vecs[n].prod);
    end

    // Reset in the middle of RUN discards the job.
    out_ready = 1'b1;
    a = 8'd200; b = 8'd100; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre-reset busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("midrun reset outputs", 64'({out_valid, busy}), 64'b00);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("after reset in_ready", 64'(in_ready), 64'd1);
    chk("after reset product", 64'({out_valid, product}), 64'd0);
    @(negedge clk);
    do_op8("post-reset 7x9", 8'd7, 8'd9, 0, 1'b0, 16'd63);

    // Random sweep against a*b.
    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] rx, ry;
      rx = W'($urandom_range(0, 255));
      ry = W'($urandom_range(0, 255));
      do_op8("rand", rx, ry, int'($urandom_range(0, 2)), 1'b0, 16'(int'(rx) * int'(ry)));
    end

    // Exhaustive WIDTH=4.
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        do_op4(W4'(x), W4'(y));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
